// File: rtl/norm_vec_serializer_if.sv
// Bus bundle for norm_vec_serializer: four divider lanes in, serial element stream out.
interface norm_vec_serializer_if #(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned EW = 2 * DATAWIDTH + 2;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_valid_A;
    logic          i_valid_B;
    logic          i_valid_C;
    logic          i_valid_D;
    logic [EW-1:0] i_data_A;
    logic [EW-1:0] i_data_B;
    logic [EW-1:0] i_data_C;
    logic [EW-1:0] i_data_D;
    logic          i_ready;
    logic          o_valid;
    logic [EW-1:0] o_data;
    logic [1:0]    o_idx;
    logic          o_last;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_lane_err;

    modport slave (
        input  i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        input  i_data_A, i_data_B, i_data_C, i_data_D,
        input  i_ready,
        output o_valid, o_data, o_idx, o_last, o_count, o_overflow, o_lane_err
    );

    modport master (
        output i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        output i_data_A, i_data_B, i_data_C, i_data_D,
        output i_ready,
        input  o_valid, o_data, o_idx, o_last, o_count, o_overflow, o_lane_err
    );
endinterface

// File: rtl/norm_vec_serializer.sv
// Captures 4-lane normalised vectors into a small FIFO and streams them out A,B,C,D.
// Optional read-path clamp to 1.0 enabled by defining NORM_CLAMP_EN.
module norm_vec_serializer #(
    parameter int unsigned DATAWIDTH   = 8,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned INSTANCE_ID = 0
) (
    input logic                  clk,
    input logic                  rst,
    norm_vec_serializer_if.slave bus
);
    localparam int unsigned EW = 2 * DATAWIDTH + 2;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_EMPTY,
        S_SEND
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0][EW-1:0]       mem [FIFO_DEPTH];

    logic                     all_valid, any_valid;
    logic                     xfer, pop, push, drop, lane_mis;
    logic                     head_from_push;
    logic [CW-1:0]            cnt_after_pop;
    logic [EW-1:0]            elem_d;

    logic                     valid_q, last_q, ovf_q, lane_err_q;
    logic [EW-1:0]            data_q;
    logic [1:0]               idx_out_q;

    logic                     unused_id;
    assign unused_id = ^32'(INSTANCE_ID);

    // Read-path conditioning of a stored quotient.
    function automatic logic [EW-1:0] read_path(input logic [EW-1:0] e);
`ifdef NORM_CLAMP_EN
        logic [EW-1:0] one_fx;
        one_fx = EW'(1) << FRAC_BITS;
        return (e > one_fx) ? one_fx : e;
`else
        return e;
`endif
    endfunction

    // Next-state, FIFO bookkeeping and next output values.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        all_valid      = bus.i_valid_A & bus.i_valid_B & bus.i_valid_C & bus.i_valid_D;
        any_valid      = bus.i_valid_A | bus.i_valid_B | bus.i_valid_C | bus.i_valid_D;
        xfer           = (state_q == S_SEND) & bus.i_ready;
        pop            = xfer & (idx_q == 2'd3);
        lane_mis       = any_valid & ~all_valid;
        cnt_after_pop  = cnt_q - CW'(pop);
        // Fullness is judged after a same-cycle pop so a streaming FIFO never drops.
        drop           = all_valid & (cnt_after_pop == CW'(FIFO_DEPTH));
        push           = all_valid & ~drop;
        cnt_d          = cnt_after_pop + CW'(push);
        rd_ptr_d       = rd_ptr_q + PW'(pop);
        wr_ptr_d       = wr_ptr_q + PW'(push);
        head_from_push = push & (cnt_after_pop == '0);
        elem_d         = '0;

        if (xfer) begin
            idx_d = (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
        end

        case (state_q)
            S_EMPTY: state_d = (cnt_d != '0) ? S_SEND : S_EMPTY;
            S_SEND:  state_d = (cnt_d != '0) ? S_SEND : S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        // The incoming vector only becomes the head when nothing older remains.
        if (state_d == S_SEND) begin
            elem_d = head_from_push ? bus.i_data_A : mem[rd_ptr_d][idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            idx_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            idx_out_q  <= '0;
            last_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lane_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= (state_d == S_SEND);
            data_q     <= read_path(elem_d);
            idx_out_q  <= (state_d == S_SEND) ? idx_d : 2'd0;
            last_q     <= (state_d == S_SEND) & (idx_d == 2'd3);
            ovf_q      <= ovf_q | drop;
            lane_err_q <= lane_err_q | lane_mis;
        end
    end

    // Vector storage; element 0 is lane A.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q][0] <= bus.i_data_A;
            mem[wr_ptr_q][1] <= bus.i_data_B;
            mem[wr_ptr_q][2] <= bus.i_data_C;
            mem[wr_ptr_q][3] <= bus.i_data_D;
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_idx      = idx_out_q;
    assign bus.o_last     = last_q;
    assign bus.o_count    = cnt_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_lane_err = lane_err_q;
endmodule

// File: tb/tb_norm_vec_serializer.sv
// Directed self-checking bench for norm_vec_serializer (DATAWIDTH=8, FIFO_DEPTH=4).
module tb_norm_vec_serializer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    norm_vec_serializer_if #(.DATAWIDTH(8), .FIFO_DEPTH(4)) bus ();

    norm_vec_serializer #(
        .DATAWIDTH(8), .FRAC_BITS(8), .FIFO_DEPTH(4), .INSTANCE_ID(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] c, input logic [17:0] d);
        bus.i_valid_A = 1'b1; bus.i_valid_B = 1'b1;
        bus.i_valid_C = 1'b1; bus.i_valid_D = 1'b1;
        bus.i_data_A = a; bus.i_data_B = b; bus.i_data_C = c; bus.i_data_D = d;
        step();
        bus.i_valid_A = 1'b0; bus.i_valid_B = 1'b0;
        bus.i_valid_C = 1'b0; bus.i_valid_D = 1'b0;
    endtask

    task automatic chk_elem(input string tag, input logic [17:0] data, input logic [1:0] idx);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
        chk({tag, ".data"},  32'(bus.o_data),  32'(data));
        chk({tag, ".idx"},   32'(bus.o_idx),   32'(idx));
        chk({tag, ".last"},  32'(bus.o_last),  32'(idx == 2'd3));
    endtask

    initial begin
        logic [17:0] exp_a, exp_b, exp_c;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_valid_A = 1'b0; bus.i_valid_B = 1'b0;
        bus.i_valid_C = 1'b0; bus.i_valid_D = 1'b0;
        bus.i_data_A = '0; bus.i_data_B = '0; bus.i_data_C = '0; bus.i_data_D = '0;
        bus.i_ready = 1'b0;
        step(); step();

        // Reset state
        chk("rst.valid", 32'(bus.o_valid), 32'd0);
        chk("rst.count", 32'(bus.o_count), 32'd0);
        chk("rst.data",  32'(bus.o_data),  32'd0);
        chk("rst.idx",   32'(bus.o_idx),   32'd0);
        chk("rst.last",  32'(bus.o_last),  32'd0);
        chk("rst.ovf",   32'(bus.o_overflow), 32'd0);
        chk("rst.lane",  32'(bus.o_lane_err), 32'd0);
        rst = 1'b1;
        step();

        // Single vector, i_ready high throughout
        bus.i_ready = 1'b1;
        push(18'h99, 18'hCC, 18'h0, 18'h0);
        chk_elem("v1.e0", 18'h99, 2'd0);
        chk("v1.count", 32'(bus.o_count), 32'd1);
        step(); chk_elem("v1.e1", 18'hCC, 2'd1);
        step(); chk_elem("v1.e2", 18'h0, 2'd2);
        step(); chk_elem("v1.e3", 18'h0, 2'd3);
        step();
        chk("v1.done.valid", 32'(bus.o_valid), 32'd0);
        chk("v1.done.count", 32'(bus.o_count), 32'd0);

        // Backpressure at idx 1
        push(18'h11, 18'hCC, 18'h33, 18'h44);
        chk_elem("bp.e0", 18'h11, 2'd0);
        step(); chk_elem("bp.e1", 18'hCC, 2'd1);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_elem("bp.hold", 18'hCC, 2'd1);
        end
        bus.i_ready = 1'b1;
        step(); chk_elem("bp.e2", 18'h33, 2'd2);
        step(); chk_elem("bp.e3", 18'h44, 2'd3);
        step(); chk("bp.done.valid", 32'(bus.o_valid), 32'd0);

        // Overflow: five pushes into a depth-4 FIFO with no consumer
        bus.i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(18'(k), 18'(k + 16), 18'(k + 32), 18'(k + 48));
        end
        chk("ovf.count4", 32'(bus.o_count), 32'd4);
        chk("ovf.pre", 32'(bus.o_overflow), 32'd0);
        push(18'd5, 18'd21, 18'd37, 18'd53);
        chk("ovf.count", 32'(bus.o_count), 32'd4);
        chk("ovf.flag",  32'(bus.o_overflow), 32'd1);
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk_elem("ovf.drainA", 18'(k), 2'd0);
            step(); step(); step();
            chk_elem("ovf.drainD", 18'(k + 48), 2'd3);
            step();
        end
        chk("ovf.empty.valid", 32'(bus.o_valid), 32'd0);
        chk("ovf.empty.count", 32'(bus.o_count), 32'd0);
        chk("ovf.sticky", 32'(bus.o_overflow), 32'd1);

        // Lane mismatch: only A and C valid
        bus.i_valid_A = 1'b1; bus.i_valid_C = 1'b1;
        bus.i_data_A = 18'h7; bus.i_data_C = 18'h8;
        step();
        bus.i_valid_A = 1'b0; bus.i_valid_C = 1'b0;
        chk("lane.count", 32'(bus.o_count), 32'd0);
        chk("lane.valid", 32'(bus.o_valid), 32'd0);
        chk("lane.flag",  32'(bus.o_lane_err), 32'd1);
        step(); step();
        chk("lane.sticky", 32'(bus.o_lane_err), 32'd1);

        // Asynchronous reset between edges clears sticky flags
        #2;
        rst = 1'b0;
        #1;
        chk("arst.lane", 32'(bus.o_lane_err), 32'd0);
        chk("arst.ovf",  32'(bus.o_overflow), 32'd0);
        chk("arst.count", 32'(bus.o_count), 32'd0);
        #2;
        rst = 1'b1;
        step();

        // Full FIFO with a push on the closing transfer of the head vector
        bus.i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(18'(8'h21 + k), 18'h0, 18'h0, 18'(8'h61 + k));
        end
        chk("fp.count4", 32'(bus.o_count), 32'd4);
        bus.i_ready = 1'b1;
        chk_elem("fp.e0", 18'h21, 2'd0);
        step(); step(); step();
        chk_elem("fp.e3", 18'h61, 2'd3);
        push(18'h25, 18'h0, 18'h0, 18'h65);
        chk("fp.count", 32'(bus.o_count), 32'd4);
        chk("fp.ovf",   32'(bus.o_overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk_elem("fp.drainA", 18'(8'h21 + k), 2'd0);
            step(); step(); step();
            chk_elem("fp.drainD", 18'(8'h61 + k), 2'd3);
            step();
        end
        chk("fp.empty.valid", 32'(bus.o_valid), 32'd0);
        chk("fp.empty.count", 32'(bus.o_count), 32'd0);

        // Read-path clamp at 1.0 = 0x100
`ifdef NORM_CLAMP_EN
        exp_a = 18'h100; exp_b = 18'hFF; exp_c = 18'h100;
`else
        exp_a = 18'h101; exp_b = 18'hFF; exp_c = 18'h3FFFF;
`endif
        push(18'h101, 18'hFF, 18'h3FFFF, 18'h100);
        chk_elem("clamp.e0", exp_a, 2'd0);
        step(); chk_elem("clamp.e1", exp_b, 2'd1);
        step(); chk_elem("clamp.e2", exp_c, 2'd2);
        step(); chk_elem("clamp.e3", 18'h100, 2'd3);
        step(); chk("clamp.done.valid", 32'(bus.o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/norm_vec_serializer.md
Name: norm_vec_serializer

Overview:
- Downstream stage of the 4-lane vector normalisation pipeline (square → adder tree → sqrt → four dividers).
- Each cycle it may capture one 4-element normalised result vector, one quotient per divider lane, into a small vector FIFO.
- It emits the vector as a serial element stream, A, B, C, D in that order, on a valid/ready interface.
- The divider pipeline has no backpressure, so FIFO overflow is detected, the vector is dropped and a sticky flag is set.

Parameters:
- DATAWIDTH, 8, base input width; element width EW = 2*DATAWIDTH+2 (18 by default).
- FRAC_BITS, 8, fractional bits of divider quotient; fixed-point 1.0 = 1<<FRAC_BITS.
- FIFO_DEPTH, 4, vector entries; power of two, ≥2.
- INSTANCE_ID, 0, instance tag, no functional effect.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid_A, i_valid_B, i_valid_C, i_valid_D  in  1 each  per-lane divider valid.
- i_data_A, i_data_B, i_data_C, i_data_D  in  EW each  per-lane quotient.
- o_valid  out  1  output element valid.
- i_ready  in  1  consumer ready.
- o_data  out  EW  current element.
- o_idx  out  2  element index: 0=A, 1=B, 2=C, 3=D.
- o_last  out  1  high when o_idx==3.
- o_count  out  $clog2(FIFO_DEPTH)+1  vectors stored.
- o_overflow  out  1  sticky: a vector was dropped.
- o_lane_err  out  1  sticky: lane valids disagreed.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, pointers 0, element index 0, o_count=0, o_valid=0, o_overflow=0, o_lane_err=0. o_data/o_idx/o_last read 0 while empty.
- Capture condition: all four i_valid_* high in the same cycle. The vector {A,B,C,D} is written at that edge.
- Partial valids (some but not all high): no write; o_lane_err set next cycle and held until reset.
- Push when FIFO full and no pop this cycle: vector dropped, FIFO unchanged, o_overflow set and held until reset.
- Push when full and a pop occurs the same cycle: push accepted, o_count unchanged. Fullness is evaluated after the same-cycle pop.
- Output side, two states:
  - EMPTY: o_valid=0.
  - SEND: o_valid=1; o_data = head vector element[idx]; o_idx = idx; o_last = (idx==3).
- Transfer = o_valid & i_ready.
  - On a transfer with idx<3: idx increments.
  - On a transfer with idx==3: head popped, idx→0. Next state is SEND if entries remain (including a same-cycle push), else EMPTY.
- Stability: while o_valid & !i_ready, o_data, o_idx and o_last hold stable. A new push never alters the head.
- Latency: a vector written at edge N gives o_valid=1 after edge N (element A visible in cycle N+1) if the FIFO was empty. No write-to-read bypass.
- Throughput: 1 element/cycle with i_ready held high, i.e. one vector per 4 cycles. A sustained push rate above 1 per 4 cycles eventually overflows; this is expected and flagged.
- Pointers: $clog2(FIFO_DEPTH) bits, natural wrap. o_count tracks push − pop.
- Reset mid-stream: partial vector transfer abandoned, idx→0, all stored vectors discarded.

Optional Feature:
- Macro: NORM_CLAMP_EN.
- Defined: o_data = min(element, 1<<FRAC_BITS) (unsigned compare). This corrects quotients above 1.0 caused by integer-truncated sqrt. Clamping is applied on the read path only; stored data is unmodified.
- Undefined: o_data passes the stored element through unchanged.

Test Plan:
- Single vector: all valids high for 1 cycle with A=0x99, B=0xCC, C=0, D=0 → next cycle o_valid=1; with i_ready=1 the stream is 0x99/idx0, 0xCC/idx1, 0/idx2, 0/idx3 with o_last=1; then o_valid=0 and o_count=0.
- Backpressure: i_ready low for 3 cycles mid-vector (idx=1) → o_data=0xCC and o_idx=1 held; resumes with no loss or duplication.
- Overflow: FIFO_DEPTH=4, i_ready=0, push 5 vectors tagged A=1..5 → o_count=4, o_overflow=1; drain yields A=1..4 only.
- Full with simultaneous pop: FIFO full, push on the cycle of the idx==3 transfer → push accepted, o_count stays 4, o_overflow stays 0.
- Lane mismatch: only i_valid_A and i_valid_C high → no write, o_count=0, o_lane_err=1 until reset; asserting rst clears it asynchronously.
- NORM_CLAMP_EN defined: A=0x101 with FRAC_BITS=8 → o_data=0x100; A=0xFF → 0xFF. Without the macro: 0x101 is output unchanged.
